// File: rtl/poly_mem_writer.sv
// poly_mem_writer
// Feeds the 13-bit coefficient memories of the SNTRUP757 datapath. Each
// accepted signed coefficient is reduced to [0, Q) and written to
// BASE_ADDR + index. The write enable, address and data are all registered.
// After P coefficients the block pulses done.
//
// Optional feature: define WRITER_PAD_EN to zero-fill offsets P..PAD_LEN-1
// before done.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting coefficients, one write per accepted beat
// PAD   | zero-filling the padded tail (WRITER_PAD_EN only)
// FIN   | one-cycle done pulse, busy dropped
module poly_mem_writer #(
   parameter int P             = 757,
   parameter int Q             = 4591,
   parameter int RAM_WIDTH     = 13,
   parameter int RAM_ADDR_BITS = 11,
   parameter int BASE_ADDR     = 0,
   parameter int PAD_LEN       = 768
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic [13:0]              in_data,
   output logic                     in_ready,
   output logic                     write_enable,
   output logic [RAM_ADDR_BITS-1:0] write_address,
   output logic [RAM_WIDTH-1:0]     input_data,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   // The counter is sized for the larger of P and PAD_LEN so that one
   // counter serves both the load and pad phases.
   localparam int CNT_MAX = (PAD_LEN > P) ? PAD_LEN : P;
   localparam int IDX_W   = $clog2(CNT_MAX + 1);

   localparam logic signed [13:0]         Q_S    = 14'(Q);
   localparam logic signed [13:0]         NEG_Q  = 14'(-Q);
   localparam logic [RAM_ADDR_BITS-1:0]   BASE_A = RAM_ADDR_BITS'(BASE_ADDR);
   localparam logic [IDX_W-1:0]           LAST_P = IDX_W'(P - 1);

`ifdef WRITER_PAD_EN
   localparam bit               HAS_PAD  = (PAD_LEN > P);
   localparam logic [IDX_W-1:0] LAST_PAD = IDX_W'(PAD_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FIN  = 2'd2,
      PAD  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FIN  = 2'd2
   } state_t;
`endif

   state_t                   state_q;
   logic [IDX_W-1:0]         idx_q;
   logic                     in_ready_q;
   logic                     we_q;
   logic [RAM_ADDR_BITS-1:0] addr_q;
   logic [RAM_WIDTH-1:0]     data_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     err_q;

   logic signed [13:0]       x_s;
   logic [RAM_WIDTH-1:0]     red_d;
   logic                     oor_d;
   logic                     accept;

   assign accept = in_valid && in_ready_q;

   // Reduce the incoming signed coefficient into [0, Q), and flag values outside (-Q, Q).
   always_comb begin
      x_s   = signed'(in_data);
      red_d = '0;
      oor_d = 1'b0;
      if (!x_s[13] && (x_s < Q_S)) begin
         red_d = RAM_WIDTH'(x_s);
      end else if (x_s[13] && (x_s > NEG_Q)) begin
         red_d = RAM_WIDTH'(x_s + Q_S);
      end else begin
         oor_d = 1'b1;
      end
   end

   // Sequencing FSM. All outputs are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= LOAD;
                  idx_q      <= '0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b1;
               end
            end
            LOAD: begin
               if (accept) begin
                  we_q   <= 1'b1;
                  addr_q <= BASE_A + RAM_ADDR_BITS'(idx_q);
                  data_q <= red_d;
                  idx_q  <= idx_q + IDX_W'(1);
                  if (oor_d) begin
                     err_q <= 1'b1;
                  end
                  if (idx_q == LAST_P) begin
                     in_ready_q <= 1'b0;
`ifdef WRITER_PAD_EN
                     if (HAS_PAD) begin
                        state_q <= PAD;
                     end else begin
                        state_q <= FIN;
                     end
`else
                     state_q <= FIN;
`endif
                  end
               end
            end
`ifdef WRITER_PAD_EN
            PAD: begin
               we_q   <= 1'b1;
               addr_q <= BASE_A + RAM_ADDR_BITS'(idx_q);
               data_q <= '0;
               idx_q  <= idx_q + IDX_W'(1);
               if (idx_q == LAST_PAD) begin
                  state_q <= FIN;
               end
            end
`endif
            FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_q;
   assign write_enable  = we_q;
   assign write_address = addr_q;
   assign input_data    = data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule
